// File: rtl/hfrv_trace_pkg.sv
// Shared types for the retire-trace capture slice: record layout and FSM states.
package hfrv_trace_pkg;

    // Width of the seq/cycle fields carried inside a stored record.
    localparam int unsigned TRACE_CNT_W = 32;

    typedef enum logic {
        IDLE,
        STAGED
    } trace_state_e;

    typedef struct packed {
        logic [31:0]            pc;
        logic [31:0]            instr;
        logic [31:0]            addr;
        logic [31:0]            wdata;
        logic [31:0]            rdata;
        logic [3:0]             we;
        logic                   has_mem;
        logic                   multi_mem;
        logic [TRACE_CNT_W-1:0] seq;
        logic [TRACE_CNT_W-1:0] cycle;
    } trace_rec_t;

    localparam int unsigned REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/hfrv_retire_trace_if.sv
// Record stream from the trace stage to the monitor (valid/ready handshake).
interface hfrv_retire_trace_if #(
    parameter int CNT_W = 32
) ();
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [31:0]      out_addr;
    logic [31:0]      out_wdata;
    logic [31:0]      out_rdata;
    logic [3:0]       out_we;
    logic             out_has_mem;
    logic             out_multi_mem;
    logic [CNT_W-1:0] out_seq;
    logic [CNT_W-1:0] out_cycle;

    modport master (
        output out_valid, out_pc, out_instr, out_addr, out_wdata, out_rdata,
               out_we, out_has_mem, out_multi_mem, out_seq, out_cycle,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pc, out_instr, out_addr, out_wdata, out_rdata,
               out_we, out_has_mem, out_multi_mem, out_seq, out_cycle,
        output out_ready
    );
endinterface

// File: rtl/hfrv_trace_fifo.sv
// First-word fall-through FIFO of trace records. Accepts a push while full
// only when the same cycle pops; callers decide what a refused push means.
module hfrv_trace_fifo
    import hfrv_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  trace_rec_t               push_rec,
    input  logic                     pop,
    output trace_rec_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    trace_rec_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_rec;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/hfrv_retire_trace.sv
// Retire-trace capture: folds each retire and its data access into one
// stamped record, buffers records and counts those lost to a full FIFO.
module hfrv_retire_trace
    import hfrv_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    instr_valid,
    input  logic [31:0]             instr_pc,
    input  logic [31:0]             instr_word,
    input  logic                    mem_access,
    input  logic [3:0]              mem_we,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    input  logic                    flush,
    hfrv_retire_trace_if.master     out_if,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_count
);
    trace_state_e     state;
    trace_rec_t       staged;
    trace_rec_t       new_rec;
    trace_rec_t       head;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] seq_cnt;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign push = (state == STAGED) && (instr_valid || flush);
    assign pop  = out_if.out_valid && out_if.out_ready;

    // Record for an instruction retiring this cycle; a same-cycle access belongs to it.
    always_comb begin
        new_rec       = '0;
        new_rec.pc    = instr_pc;
        new_rec.instr = instr_word;
        new_rec.seq   = TRACE_CNT_W'(seq_cnt);
        new_rec.cycle = TRACE_CNT_W'(cycle_cnt);
        if (mem_access) begin
            new_rec.has_mem = 1'b1;
            new_rec.addr    = mem_addr;
            new_rec.we      = mem_we;
            new_rec.wdata   = mem_wdata;
            new_rec.rdata   = mem_rdata;
        end
    end

    // Staging FSM, free-running counters and drop accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            staged     <= '0;
            cycle_cnt  <= '0;
            seq_cnt    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (instr_valid) begin
                seq_cnt <= seq_cnt + CNT_W'(1);
            end

            if (instr_valid) begin
                staged <= new_rec;
                state  <= STAGED;
            end else if (state == STAGED) begin
                if (flush) begin
                    state <= IDLE;
                end else if (mem_access) begin
                    if (!staged.has_mem) begin
                        staged.has_mem <= 1'b1;
                        staged.addr    <= mem_addr;
                        staged.we      <= mem_we;
                        staged.wdata   <= mem_wdata;
                        staged.rdata   <= mem_rdata;
                    end else begin
                        staged.multi_mem <= 1'b1;
                    end
                end
            end

            if (push && full && !pop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_W'(1);
                end
            end
        end
    end

    hfrv_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_rec (staged),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    assign out_if.out_valid     = !empty;
    assign out_if.out_pc        = head.pc;
    assign out_if.out_instr     = head.instr;
    assign out_if.out_addr      = head.addr;
    assign out_if.out_wdata     = head.wdata;
    assign out_if.out_rdata     = head.rdata;
    assign out_if.out_we        = head.we;
    assign out_if.out_has_mem   = head.has_mem;
    assign out_if.out_multi_mem = head.multi_mem;
    assign out_if.out_seq       = head.seq[CNT_W-1:0];
    assign out_if.out_cycle     = head.cycle[CNT_W-1:0];
endmodule

// File: tb/tb_hfrv_retire_trace.sv
// Directed bench for hfrv_retire_trace: expected values are hand-derived.
module tb_hfrv_retire_trace;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] instr_word;
    logic        mem_access;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        flush;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_count;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int exp_seq    = 0;
    int stamp [64];

    hfrv_retire_trace_if #(.CNT_W(32)) oif ();

    hfrv_retire_trace #(
        .DEPTH  (16),
        .CNT_W  (32),
        .DROP_W (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
        .instr_word  (instr_word),
        .mem_access  (mem_access),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .flush       (flush),
        .out_if      (oif.master),
        .level       (level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs are sampled on it, outputs checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        instr_valid = 1'b0;
        mem_access  = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset   = 1'b0;
        cyc     = 0;
        exp_seq = 0;
    endtask

    task automatic drive_mem(input logic [31:0] a, input logic [3:0] we,
                             input logic [31:0] wd, input logic [31:0] rd);
        mem_access = 1'b1;
        mem_addr   = a;
        mem_we     = we;
        mem_wdata  = wd;
        mem_rdata  = rd;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] word);
        instr_valid = 1'b1;
        instr_pc    = pc;
        instr_word  = word;
        stamp[exp_seq] = cyc;
        exp_seq++;
        step();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
    endtask

    task automatic pop_one();
        oif.out_ready = 1'b1;
        step();
        oif.out_ready = 1'b0;
    endtask

    initial begin
        instr_valid = 1'b0; instr_pc = '0; instr_word = '0;
        mem_access = 1'b0; mem_we = '0; mem_addr = '0; mem_wdata = '0; mem_rdata = '0;
        flush = 1'b0; oif.out_ready = 1'b0; reset = 1'b1;
        step();
        do_reset();

        chk("rst_valid", oif.out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_pc", oif.out_pc, 0);
        chk("rst_seq", oif.out_seq, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_count, 0);

        // Retires at cycles 3 and 5, flush at 7.
        step(); step(); step();
        retire(32'h100, 32'h00000013);
        step();
        chk("t1_not_yet", oif.out_valid, 0);
        retire(32'h104, 32'h00000013);
        chk("t1_first_valid", oif.out_valid, 1);
        step();
        do_flush();
        chk("t1_level", level, 2);
        chk("t1_pc0", oif.out_pc, 32'h100);
        chk("t1_seq0", oif.out_seq, 0);
        chk("t1_cyc0", oif.out_cycle, 3);
        chk("t1_mem0", oif.out_has_mem, 0);
        step();
        chk("t1_hold_pc", oif.out_pc, 32'h100);
        pop_one();
        chk("t1_pc1", oif.out_pc, 32'h104);
        chk("t1_seq1", oif.out_seq, 1);
        chk("t1_cyc1", oif.out_cycle, 5);
        pop_one();
        chk("t1_empty", oif.out_valid, 0);

        // Load with its access two cycles after retire.
        retire(32'h200, 32'h00052283);
        step();
        drive_mem(32'h8000, 4'h0, 32'h0, 32'hDEADBEEF);
        step();
        retire(32'h204, 32'h00B52023);
        chk("t2_pc", oif.out_pc, 32'h200);
        chk("t2_has_mem", oif.out_has_mem, 1);
        chk("t2_addr", oif.out_addr, 32'h8000);
        chk("t2_we", oif.out_we, 0);
        chk("t2_rdata", oif.out_rdata, 32'hDEADBEEF);
        chk("t2_multi", oif.out_multi_mem, 0);
        chk("t2_seq", oif.out_seq, 2);
        chk("t2_cyc", oif.out_cycle, stamp[2]);
        pop_one();

        // Two accesses on the staged 0x204 record; first one is kept.
        drive_mem(32'h8800, 4'hF, 32'h11223344, 32'h0);
        step();
        drive_mem(32'h9000, 4'h3, 32'h0000AAAA, 32'h0);
        step();
        do_flush();
        chk("t3_pc", oif.out_pc, 32'h204);
        chk("t3_multi", oif.out_multi_mem, 1);
        chk("t3_addr", oif.out_addr, 32'h8800);
        chk("t3_we", oif.out_we, 4'hF);
        chk("t3_wdata", oif.out_wdata, 32'h11223344);
        chk("t3_seq", oif.out_seq, 3);
        pop_one();

        // Access in the same cycle as retire attaches to the new record.
        drive_mem(32'hA000, 4'h0, 32'h0, 32'h5555AAAA);
        retire(32'h300, 32'h00052283);
        do_flush();
        chk("t3b_pc", oif.out_pc, 32'h300);
        chk("t3b_has_mem", oif.out_has_mem, 1);
        chk("t3b_addr", oif.out_addr, 32'hA000);
        chk("t3b_rdata", oif.out_rdata, 32'h5555AAAA);
        chk("t3b_seq", oif.out_seq, 4);
        pop_one();
        chk("t3b_empty", oif.out_valid, 0);

        // Access while IDLE has no owner.
        drive_mem(32'hB000, 4'hF, 32'h1, 32'h0);
        step();
        retire(32'h400, 32'h00000013);
        do_flush();
        chk("t3c_pc", oif.out_pc, 32'h400);
        chk("t3c_has_mem", oif.out_has_mem, 0);
        chk("t3c_seq", oif.out_seq, 5);
        pop_one();

        // Overflow: 20 retires plus flush into a 16-entry FIFO.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            retire(32'h1000 + 32'(4 * i), 32'h00000013);
        end
        do_flush();
        chk("t4_level", level, 16);
        chk("t4_ovf", overflow, 1);
        chk("t4_drop", drop_count, 4);
        chk("t4_head_seq", oif.out_seq, 0);
        chk("t4_head_pc", oif.out_pc, 32'h1000);

        // Push into a full FIFO alongside a pop.
        retire(32'h2000, 32'h00000013);
        oif.out_ready = 1'b1;
        retire(32'h2004, 32'h00000013);
        oif.out_ready = 1'b0;
        chk("t5_level", level, 16);
        chk("t5_drop", drop_count, 4);
        for (int i = 1; i < 16; i++) begin
            chk("t5_drain_seq", oif.out_seq, 64'(i));
            chk("t5_drain_pc", oif.out_pc, 64'(32'h1000 + 32'(4 * i)));
            pop_one();
        end
        chk("t5_after_gap_seq", oif.out_seq, 20);
        chk("t5_after_gap_pc", oif.out_pc, 32'h2000);
        chk("t5_after_gap_cyc", oif.out_cycle, stamp[20]);
        pop_one();
        do_flush();
        chk("t5_last_seq", oif.out_seq, 21);
        pop_one();
        chk("t5_empty", oif.out_valid, 0);

        // Reset while STAGED with five records queued.
        for (int i = 0; i < 6; i++) begin
            retire(32'h3000 + 32'(4 * i), 32'h00000013);
        end
        chk("t6_level_pre", level, 5);
        do_reset();
        chk("t6_valid", oif.out_valid, 0);
        chk("t6_level", level, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_drop", drop_count, 0);
        chk("t6_pc", oif.out_pc, 0);
        retire(32'h5000, 32'h00000013);
        do_flush();
        chk("t6_seq", oif.out_seq, 0);
        chk("t6_cyc", oif.out_cycle, 0);
        chk("t6_new_pc", oif.out_pc, 32'h5000);
        chk("t6_level_post", level, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
